// File: rtl/mul2add_pkg.sv
// Shared definitions for the mul2add block.
// Holds the FSM state encoding and the default quotient width.
package mul2add_pkg;

  localparam int unsigned DefaultWidth = 8;

  // 2'b11 is unreachable in normal operation and is decoded back to idle.
  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StShift   = 2'b01,
    StOut     = 2'b10,
    StIllegal = 2'b11
  } mul2add_state_e;

endpackage

// File: rtl/shiftl_ins.sv
// Left-shift register with serial insert into the LSB.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low clear
//   load_i     - parallel load of load_val_i (has priority over shift_i)
//   load_val_i - parallel load value
//   shift_i    - shift left by one and insert sin_i at the LSB
//   sin_i      - serial bit inserted at the LSB
//   q_o        - register contents
// The register holds its value when neither load_i nor shift_i is asserted.
module shiftl_ins #(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {q_q[Width-2:0], sin_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mul2add.sv
// Reconstructs a = 2*div2 + mod2 over three clock edges:
// capture (idle), shift-in of the remainder bit, then register the result.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   activate - start request, only sampled while idle
//   div2     - quotient operand (WIDTH bits)
//   mod2     - remainder operand
//   a        - registered result (WIDTH+1 bits), held between operations
//   endop    - registered one-cycle done pulse
//   busy     - only when MUL2ADD_BUSY_EN is defined: high while an
//              operation is in flight (shift and out states)
module mul2add
  import mul2add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic [WIDTH-1:0] div2,
  input  logic             mod2,
  output logic [WIDTH:0]   a,
  output logic             endop
`ifdef MUL2ADD_BUSY_EN
  ,
  output logic             busy
`endif
);

  mul2add_state_e state_d, state_q;

  logic           load_en, shift_en, out_en;
  logic           mod_q;
  logic [WIDTH:0] sreg;
  logic [WIDTH:0] a_q;
  logic           endop_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (activate) state_d = StShift;
      StShift: state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    out_en   = 1'b0;
    case (state_q)
      StIdle:  load_en  = activate;
      StShift: shift_en = 1'b1;
      StOut:   out_en   = 1'b1;
      default: ;
    endcase
  end

  shiftl_ins #(
    .Width (WIDTH + 1)
  ) u_shiftl_ins (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (load_en),
    .load_val_i ({1'b0, div2}),
    .shift_i    (shift_en),
    .sin_i      (mod_q),
    .q_o        (sreg)
  );

  // Remainder bit is held from capture until it is shifted in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mod_q <= 1'b0;
    end else if (load_en) begin
      mod_q <= mod2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      endop_q <= 1'b0;
    end else begin
      endop_q <= out_en;
      if (out_en) begin
        a_q <= sreg;
      end
    end
  end

  assign a     = a_q;
  assign endop = endop_q;

`ifdef MUL2ADD_BUSY_EN
  assign busy = (state_q == StShift) || (state_q == StOut);
`endif

endmodule

// File: tb/tb_mul2add.sv
// Scoreboard bench for mul2add: the driver pushes the expected result and
// the cycle it must appear on; a negedge monitor pops on every endop.
module tb_mul2add;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         activate;
  logic [W-1:0] div2;
  logic         mod2;
  logic [W:0]   a;
  logic         endop;
`ifdef MUL2ADD_BUSY_EN
  logic         busy;
`endif

  mul2add #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .activate (activate),
    .div2     (div2),
    .mod2     (mod2),
    .a        (a),
    .endop    (endop)
`ifdef MUL2ADD_BUSY_EN
    ,
    .busy     (busy)
`endif
  );

  typedef struct {
    int exp_a;
    int exp_cyc;
  } sb_item_t;

  sb_item_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int a_model = 0;
  int last_cap = -100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (endop) begin
        if (sb.size() == 0) begin
          chk("unexpected_endop", 1, 0);
        end else begin
          sb_item_t it;
          it = sb.pop_front();
          chk("result_a", int'(a), it.exp_a);
          chk("endop_latency", cyc, it.exp_cyc);
          a_model = it.exp_a;
        end
      end else begin
        chk("hold_a", int'(a), a_model);
      end
`ifdef MUL2ADD_BUSY_EN
      chk("busy", int'(busy), int'(cyc == last_cap || cyc == last_cap + 1));
`endif
    end
  end

  // Issue one operation starting in an idle cycle; operands and activate are
  // scrambled during the in-flight cycles to prove they are ignored.
  task automatic do_op(input logic [W-1:0] d, input logic m);
    activate = 1'b1;
    div2     = d;
    mod2     = m;
    @(posedge clk);
    #1;
    last_cap = cyc;
    sb.push_back('{exp_a: 2 * int'(d) + int'(m), exp_cyc: cyc + 2});
    repeat (2) begin
      activate = 1'($urandom);
      div2     = W'($urandom);
      mod2     = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    activate = 1'b0;
    repeat (n) begin
      div2 = W'($urandom);
      mod2 = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    activate = 1'b0;
    div2     = '0;
    mod2     = 1'b0;
    #12;
    chk("reset_a", int'(a), 0);
    chk("reset_endop", int'(endop), 0);
`ifdef MUL2ADD_BUSY_EN
    chk("reset_busy", int'(busy), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Directed vectors.
    do_op(8'h7F, 1'b1);
    idle(1);
    do_op(8'hFF, 1'b1);
    do_op(8'h00, 1'b0);
    idle(2);

    // Abort in SHIFT: no result must emerge and a must clear.
    activate = 1'b1;
    div2     = 8'h55;
    mod2     = 1'b1;
    @(posedge clk);
    #1;
    activate = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("abort_a", int'(a), 0);
    chk("abort_endop", int'(endop), 0);
`ifdef MUL2ADD_BUSY_EN
    chk("abort_busy", int'(busy), 0);
`endif
    a_model  = 0;
    last_cap = -100;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    do_op(8'h55, 1'b0);
    idle(1);

    // Activate held high: back-to-back captures three cycles apart.
    do_op(8'h01, 1'b1);
    do_op(8'h80, 1'b1);
    idle(2);

    // Randomized operations with random idle gaps (0 = back-to-back).
    for (int i = 0; i < 60; i++) begin
      do_op(W'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    idle(6);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul2add.md
MUL2ADD -- requirements
Module: mul2add

Interface
REQ-001 SHALL expose parameter WIDTH, default 8, quotient width; result width is WIDTH+1.
REQ-002 SHALL expose: clk  input  1  single clock, rising edge.
REQ-003 SHALL expose: reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 SHALL expose: activate  input  1  start request, sampled only in IDLE.
REQ-005 SHALL expose: div2  input  WIDTH  quotient operand.
REQ-006 SHALL expose: mod2  input  1  remainder operand.
REQ-007 SHALL expose: a  output  WIDTH+1  reconstructed value 2*div2+mod2, registered.
REQ-008 SHALL expose: endop  output  1  one-cycle done pulse, registered.

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT, OUT.
REQ-010 In IDLE with activate=1 at edge N: capture sreg <= {1'b0, div2}, mod_q <= mod2, go to SHIFT. With activate=0: stay IDLE.
REQ-011 In SHIFT at edge N+1: sreg <= {sreg[WIDTH-1:0], mod_q}, go to OUT.
REQ-012 In OUT at edge N+2: a <= sreg, endop <= 1, go to IDLE.
REQ-013 endop SHALL be high for exactly the one cycle after edge N+2, and low in all other cycles.
REQ-014 Latency: a and endop valid 3 edges after activate sampled; throughput one result per 3 cycles.
REQ-015 a SHALL hold its last value until the next OUT edge; it does not change in IDLE or SHIFT.
REQ-016 activate in SHIFT or OUT SHALL be ignored. Changes to div2/mod2 after the capture edge SHALL NOT affect the result in flight.
REQ-017 activate held high SHALL restart at the IDLE edge following OUT (back-to-back, 3-cycle spacing). The new operands are sampled at that edge.
REQ-018 Result SHALL never overflow: max 2*(2^WIDTH-1)+1 = 2^(WIDTH+1)-1.

Reset
REQ-019 reset low SHALL immediately force state=IDLE, sreg=0, mod_q=0, a=0, endop=0 (and busy=0), independent of clk.
REQ-020 Reset during SHIFT or OUT SHALL abort the operation: no endop, a stays 0.
REQ-021 After reset deassertion, the first activate sampled in IDLE SHALL start a normal operation.

Configuration
REQ-022 Macro MUL2ADD_BUSY_EN defined: SHALL add output busy (1 bit, registered-state decode), high in SHIFT and OUT, low in IDLE and reset.
REQ-023 Macro MUL2ADD_BUSY_EN undefined: SHALL have no busy port. All other behaviour is identical.

Structure
REQ-024 Package mul2add_pkg SHALL hold the state encodings (IDLE=2'b00, SHIFT=2'b01, OUT=2'b10) and the default WIDTH constant.
REQ-025 The shift/capture datapath SHALL be one sub-module shiftl_ins, a (WIDTH+1)-bit register with async active-low clear and load, shift-in-LSB, and hold controls.
REQ-026 Encoding 2'b11 SHALL return to IDLE on the next edge with endop=0.

Verification
REQ-027 div2=0x7F, mod2=1, activate pulse -> a=0x0FF, endop high one cycle, 3 edges after activate.
REQ-028 div2=0xFF, mod2=1 -> a=0x1FF. div2=0x00, mod2=0 -> a=0x000 with endop still pulsing.
REQ-029 reset low during SHIFT (div2=0x55) -> a=0, endop never asserted, FSM in IDLE. Next activate with div2=0x55, mod2=0 -> a=0x0AA.
REQ-030 activate held high, div2 changes 0x01 then 0x80, mod2=1 -> endop pulses 3 cycles apart, a=0x003 then a=0x101.
REQ-031 activate toggled and div2 changed during SHIFT/OUT -> result reflects the operands sampled at the capture edge. With MUL2ADD_BUSY_EN: busy high exactly 2 cycles per operation.
